regfile_write_arbiter: RTL

- Shares the register file's single write port (WriteRegister/WriteData/RegWrite) between two writeback requesters: A (ALU result) and B (memory load data).
- Each requester has a one-entry holding buffer with a valid/ready handshake.
- Arbitration is oldest-first, with round-robin tie-break.
- Exports a pending-write mask and read-port hazard flags so the pipeline stalls reads of registers whose writes have not yet committed.

---
 rtl/regfile_pkg.sv | 32 +++
 rtl/regfile_write_arbiter_wb_hold_buf.sv | 53 +++++
 rtl/regfile_write_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and the writeback entry type used by the
//               register-file write arbiter and its holding buffers.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int DATA_W   = 64;  // write data width
  localparam int ADDR_W   = 5;   // register address width
  localparam int NREG     = 32;  // architectural registers
  localparam int ZERO_REG = 31;  // hard-wired zero register

  // One pending writeback. 'addr' is the destination register ('reg' is a
  // reserved word, so the field cannot carry that name).
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Relative age of the two holding buffers; only meaningful when both full.
  localparam logic [1:0] AGE_EQUAL   = 2'd0;
  localparam logic [1:0] AGE_A_OLDER = 2'd1;
  localparam logic [1:0] AGE_B_OLDER = 2'd2;

  // Round-robin pointer values.
  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_wb_hold_buf.sv
`default_nettype none
// ============================================================================
// Module      : wb_hold_buf
// Description : One-entry writeback holding buffer with full flag.
//               A load takes priority over a clear so that an entry granted
//               and replaced on the same edge stays full with the new value.
// Ports       : clk, reset_n  - clock, async active-low reset
//               load, din     - capture din, set full
//               clear         - drop the current entry
//               full, dout    - buffer state
// Revision    : 1.0 - initial release
// ============================================================================
module wb_hold_buf
  import regfile_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      load,
  input  logic      clear,
  input  wb_entry_t din,
  output logic      full,
  output wb_entry_t dout
);

  logic      full_q,  full_d;
  wb_entry_t entry_q, entry_d;

  always_comb begin
    full_d  = full_q;
    entry_d = entry_q;
    if (load) begin
      full_d  = 1'b1;
      entry_d = din;
    end else if (clear) begin
      full_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      full_q  <= full_d;
      entry_q <= entry_d;
    end
  end

  assign full = full_q;
  assign dout = entry_q;

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : regfile_write_arbiter
// Description : Shares the register file's single write port between an ALU
//               writeback (A) and a load writeback (B). Each side has a
//               one-entry buffer; the older buffered entry wins, equal ages
//               alternate round-robin. Exposes a pending-write mask and
//               read-port stall flags for hazard detection.
// Ports       : clk, reset_n                      - clock, async active-low reset
//               a_valid/a_ready/a_reg/a_data      - requester A handshake
//               b_valid/b_ready/b_reg/b_data      - requester B handshake
//               WriteRegister/WriteData/RegWrite  - register file write port
//               ReadRegister1/ReadRegister2       - read addresses to check
//               stall1/stall2                     - read hazards
//               pend_mask                         - uncommitted writes per reg
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_write_arbiter #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int NREG     = 32,
  parameter int ZERO_REG = 31
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic [DATA_W-1:0] WriteData,
  output logic              RegWrite,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic              stall1,
  output logic              stall2,
  output logic [NREG-1:0]   pend_mask
);

  import regfile_pkg::*;

  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

  wb_entry_t a_in, b_in, a_ent, b_ent;
  logic      a_full, b_full;
  logic      a_load, b_load;
  logic      grant_a, grant_b, tie_grant;

  logic [1:0]        age_q, age_d;
  logic              rr_q, rr_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              regwrite_q, regwrite_d;

  assign a_in.addr = a_reg;
  assign a_in.data = a_data;
  assign b_in.addr = b_reg;
  assign b_in.data = b_data;

  // --------------------------------------------------------------------------
  // Holding buffers: the granted entry retires on the commit edge.
  // --------------------------------------------------------------------------
  wb_hold_buf u_buf_a (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (a_load),
    .clear   (grant_a),
    .din     (a_in),
    .full    (a_full),
    .dout    (a_ent)
  );

  wb_hold_buf u_buf_b (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (b_load),
    .clear   (grant_b),
    .din     (b_in),
    .full    (b_full),
    .dout    (b_ent)
  );

  // --------------------------------------------------------------------------
  // Grant: sole occupant, else the older entry, else round-robin.
  // --------------------------------------------------------------------------
  always_comb begin
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    tie_grant = 1'b0;
    if (a_full && !b_full) begin
      grant_a = 1'b1;
    end else if (!a_full && b_full) begin
      grant_b = 1'b1;
    end else if (a_full && b_full) begin
      case (age_q)
        AGE_A_OLDER: grant_a = 1'b1;
        AGE_B_OLDER: grant_b = 1'b1;
        default: begin
          tie_grant = 1'b1;
          if (rr_q == REQ_A) grant_a = 1'b1;
          else               grant_b = 1'b1;
        end
      endcase
    end
  end

  // A buffer being drained this cycle can take a new entry on the same edge.
  assign a_ready = !a_full || grant_a;
  assign b_ready = !b_full || grant_b;
  assign a_load  = a_valid && a_ready;
  assign b_load  = b_valid && b_ready;

  // --------------------------------------------------------------------------
  // Age and round-robin state. A lone load is younger only if the other entry
  // survives this edge; otherwise the loaded entry will be alone and age is
  // irrelevant, so it is reset to equal.
  // --------------------------------------------------------------------------
  always_comb begin
    age_d = age_q;
    if (a_load && b_load) begin
      age_d = AGE_EQUAL;
    end else if (a_load) begin
      age_d = (b_full && !grant_b) ? AGE_B_OLDER : AGE_EQUAL;
    end else if (b_load) begin
      age_d = (a_full && !grant_a) ? AGE_A_OLDER : AGE_EQUAL;
    end else if (grant_a || grant_b) begin
      age_d = AGE_EQUAL;
    end

    rr_d = rr_q;
    if (tie_grant) rr_d = grant_a ? REQ_B : REQ_A;
  end

  // --------------------------------------------------------------------------
  // Commit register: the write port outputs are flops, so the register file
  // sees the granted entry for exactly the cycle after the grant.
  // --------------------------------------------------------------------------
  always_comb begin
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    regwrite_d = 1'b0;
    if (grant_a) begin
      wreg_d     = a_ent.addr;
      wdata_d    = a_ent.data;
      regwrite_d = (a_ent.addr != ZERO_ADDR);
    end else if (grant_b) begin
      wreg_d     = b_ent.addr;
      wdata_d    = b_ent.data;
      regwrite_d = (b_ent.addr != ZERO_ADDR);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      age_q      <= AGE_EQUAL;
      rr_q       <= REQ_A;
      wreg_q     <= '0;
      wdata_q    <= '0;
      regwrite_q <= 1'b0;
    end else begin
      age_q      <= age_d;
      rr_q       <= rr_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      regwrite_q <= regwrite_d;
    end
  end

  assign WriteRegister = wreg_q;
  assign WriteData     = wdata_q;
  assign RegWrite      = regwrite_q;

  // --------------------------------------------------------------------------
  // Pending-write mask: buffered entries plus the write now on the port.
  // --------------------------------------------------------------------------
  for (genvar r = 0; r < NREG; r++) begin : g_pend
    if (r == ZERO_REG) begin : g_zero
      assign pend_mask[r] = 1'b0;
    end else begin : g_live
      assign pend_mask[r] = (a_full     && (a_ent.addr == ADDR_W'(r))) ||
                            (b_full     && (b_ent.addr == ADDR_W'(r))) ||
                            (regwrite_q && (wreg_q     == ADDR_W'(r)));
    end
  end

  assign stall1 = pend_mask[ReadRegister1];
  assign stall2 = pend_mask[ReadRegister2];

endmodule
`default_nettype wire
